uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver. Consumes the receiver's parallel byte, its ready flag (rdrf) and its framing-error flag (FE).
- Acknowledges each byte with a one-cycle rdrf_clr pulse and stores byte plus FE tag in a show-ahead FIFO.
- Exposes the FIFO to the host/bus side through a valid/pop interface with occupancy and sticky overrun status.

Parameters:
- DATA_LENGTH, 8, width of a received character.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  DATA_LENGTH  byte from receiver; stable while rdrf=1.
- rdrf  input  1  receiver data-ready flag; treated as asynchronous, level.
- fe  input  1  receiver framing-error flag; valid with rdrf.
- rdrf_clr  output  1  one-cycle acknowledge pulse to receiver.
- rd_en  input  1  pop request from host.
- rd_data  output  DATA_LENGTH  head-of-FIFO byte (show-ahead).
- rd_fe  output  1  FE tag of head entry.
- rd_valid  output  1  FIFO not empty.
- full  output  1  count == DEPTH.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overrun  output  1  sticky: a byte arrived while full.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, active-high) clears the state machine, pointers and status flags at any time, including mid-capture.
  - State -> IDLE; synchronizer flops -> 0; pointers -> 0; count -> 0.
  - Outputs after reset: rdrf_clr=0, rd_valid=0, full=0, overrun=0.
  - rd_data and rd_fe -> 0 while empty.
  - Memory contents are not reset.
- rdrf passes through a 2-flop synchronizer (rdrf_s). fe and rx_data are sampled only in CAPTURE, which occurs after rdrf_s=1, so they are stable by then.
- State machine:
  - IDLE: if rdrf_s=1, go to CAPTURE.
  - CAPTURE: write {fe, rx_data} if there is space, else set overrun. Assert rdrf_clr this cycle only. Go to WAIT_LOW.
  - WAIT_LOW: if rdrf_s=0, go to IDLE. Each receiver assertion of rdrf is captured exactly once.
- Latency: rdrf first sampled high at edge 1 -> sync stage 2 high at edge 2 -> CAPTURE entered at edge 3 -> write and rdrf_clr at edge 4. rd_valid is high after edge 4 when the FIFO was empty.
- Write acceptance in CAPTURE:
  - Accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overrun <= 1, and rdrf_clr is still pulsed.
- Pop: rd_en=1 with rd_valid=1 advances the read pointer at the clock edge. rd_en while empty is ignored, with no underflow and no pointer change.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked explicitly and saturates at neither end.
- rd_data and rd_fe reflect mem[rd_ptr] combinationally from registered storage; they are updated the cycle after a pop or after the first write into an empty FIFO.
- overrun: set in CAPTURE on a dropped byte; cleared by overrun_clr. If set and clear occur in the same cycle, set wins.
- full = (count == DEPTH); rd_valid = (count != 0).

Optional Feature:
- Macro: UART_RX_FIFO_DROP_FE_EN.
- Defined: a byte with fe=1 is not written. It is still acknowledged with rdrf_clr and does not set overrun. rd_fe is tied to 0.
- Undefined: every byte is written, with its FE tag visible on rd_fe.

Test Plan:
- Reset, then rdrf=1, rx_data=8'hA5, fe=0 held until rdrf_clr -> exactly one rdrf_clr pulse at edge 4; rd_valid=1, rd_data=8'hA5, count=1.
- Push 16 bytes 8'h00..8'h0F, then push 8'h55 -> full=1, overrun=1, count=16. Pop 16 -> data 00..0F in order, rd_valid=0 after the last pop.
- Full FIFO: hold rd_en=1 during the CAPTURE of 8'h77 -> byte accepted, count stays 16, overrun=0, 8'h77 popped last.
- rdrf held high for 50 cycles -> single write, single rdrf_clr. Drop rdrf, re-raise with 8'h3C -> second entry 8'h3C.
- fe=1 with 8'hFF -> rd_fe=1 without UART_RX_FIFO_DROP_FE_EN; with the macro: count=0, rdrf_clr pulsed.
- Assert reset during WAIT_LOW with 3 entries -> count=0, rd_valid=0, overrun=0, rdrf_clr=0; rdrf still high after release -> captured once.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: acknowledges each byte and queues it with its FE tag.
// Optional: define UART_RX_FIFO_DROP_FE_EN to discard framing-error bytes instead of storing them.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DATA_LENGTH = 8,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] rx_data,
  input  logic                   rdrf,
  input  logic                   fe,
  output logic                   rdrf_clr,
  input  logic                   rd_en,
  output logic [DATA_LENGTH-1:0] rd_data,
  output logic                   rd_fe,
  output logic                   rd_valid,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef UART_RX_FIFO_DROP_FE_EN
  localparam int MEM_W = DATA_LENGTH;
`else
  localparam int MEM_W = DATA_LENGTH + 1;
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_LOW} state_t;

  state_t             state, next_state;
  logic               rdrf_m, rdrf_s;
  logic               capture;
  logic               pop, space, drop_fe, wr_en, ovr_set;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [MEM_W-1:0]   mem [DEPTH];
  logic [MEM_W-1:0]   head;
  logic [MEM_W-1:0]   wr_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdrf_m <= 1'b0;
      rdrf_s <= 1'b0;
    end else begin
      rdrf_m <= rdrf;
      rdrf_s <= rdrf_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    rdrf_clr   = 1'b0;
    unique case (state)
      IDLE:     if (rdrf_s) next_state = CAPTURE;
      CAPTURE: begin
        capture    = 1'b1;
        rdrf_clr   = 1'b1;
        next_state = WAIT_LOW;
      end
      WAIT_LOW: if (!rdrf_s) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_DROP_FE_EN
  assign drop_fe = fe;
  assign wr_word = rx_data;
`else
  assign drop_fe = 1'b0;
  assign wr_word = {fe, rx_data};
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop     = rd_en && rd_valid;
  assign space   = (count != FULL_CNT) || pop;
  assign wr_en   = capture && !drop_fe && space;
  assign ovr_set = capture && !drop_fe && !space;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

  assign head     = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign rd_data  = rd_valid ? head[DATA_LENGTH-1:0] : '0;
`ifdef UART_RX_FIFO_DROP_FE_EN
  assign rd_fe    = 1'b0;
`else
  assign rd_fe    = rd_valid & head[DATA_LENGTH];
`endif

endmodule
